// File: rtl/shift_collector_pkg.sv
// Shared widths and types for the serial-to-parallel byte collector.
package shift_collector_pkg;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with registered head word, valid/ready pop side and exact occupancy count.
module sync_fifo_sa #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [CNT_W-1:0] count,
   output logic             full_c
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             pop_c;
   logic             wr_c;
   logic [PTR_W-1:0] rd_next_c;
   logic [CNT_W-1:0] left_c;
   logic [CNT_W-1:0] count_next_c;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   always_comb begin
      full_c       = (count == CNT_W'(DEPTH));
      pop_c        = head_valid && ready;
      wr_c         = push && (!full_c || pop_c);
      rd_next_c    = rd_ptr + PTR_W'(pop_c);
      left_c       = count - CNT_W'(pop_c);
      count_next_c = left_c + CNT_W'(wr_c);
   end

   always_ff @(posedge clk) begin
      if (wr_c) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Head register: next stored entry, else the incoming word on an empty FIFO, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         rd_ptr     <= rd_next_c;
         wr_ptr     <= wr_ptr + PTR_W'(wr_c);
         count      <= count_next_c;
         head_valid <= (count_next_c != '0);
         if (left_c != '0) begin
            head_data <= mem[rd_next_c];
         end else if (wr_c) begin
            head_data <= push_data;
         end
      end
   end
endmodule

// File: rtl/shift_byte_collector.sv
// Counts shift strobes alongside the serial-in shift register and queues each completed word
// for a valid/ready consumer, flagging words lost while the queue is full.
module shift_byte_collector #(
   parameter int unsigned DATA_W = shift_collector_pkg::DATA_W,
   parameter int unsigned DEPTH  = shift_collector_pkg::DEPTH,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_enable,
   input  logic [DATA_W-1:0] stored_data,
   input  logic              frame_clear,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  fifo_count,
   output logic              overflow,
   input  logic              clear_overflow
);
   import shift_collector_pkg::*;

   localparam int unsigned BC_W = $clog2(DATA_W);

   logic [BC_W-1:0] bit_cnt;
   logic            capture_pending;
   logic            push_c;
   logic            drop_c;
   logic            full_c;

   // The word is complete one cycle after the last shift, so capture is deferred by a pending flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt         <= '0;
         capture_pending <= 1'b0;
      end else if (frame_clear) begin
         bit_cnt         <= '0;
         capture_pending <= 1'b0;
      end else begin
         capture_pending <= 1'b0;
         if (shift_enable) begin
            if (bit_cnt == BC_W'(DATA_W - 1)) begin
               bit_cnt         <= '0;
               capture_pending <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + BC_W'(1);
            end
         end
      end
   end

   always_comb begin
      push_c = capture_pending && !frame_clear;
      drop_c = push_c && full_c && !(out_valid && out_ready);
   end

   // Sticky loss flag; a new drop wins over a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop_c) begin
         overflow <= 1'b1;
      end else if (clear_overflow) begin
         overflow <= 1'b0;
      end
   end

   sync_fifo_sa #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_c),
      .push_data  (stored_data),
      .ready      (out_ready),
      .head_data  (out_data),
      .head_valid (out_valid),
      .count      (fifo_count),
      .full_c     (full_c)
   );
endmodule

// File: tb/tb_shift_byte_collector.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks every accepted pop.
module tb_shift_byte_collector;
   import shift_collector_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          shift_enable;
   word_t         stored_data;
   logic          frame_clear;
   word_t         out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          clear_overflow;

   int    errors = 0;
   int    checks = 0;
   word_t exp_q[$];

   shift_byte_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .shift_enable   (shift_enable),
      .stored_data    (stored_data),
      .frame_clear    (frame_clear),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   // Monitor: a pop happens at the next rising edge whenever valid and ready are both high.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %02h, required no word", out_data);
         end else begin
            word_t exp_w;
            exp_w = exp_q.pop_front();
            if (out_data !== exp_w) begin
               errors++;
               $display("FAIL pop_data: got %02h, required %02h", out_data, exp_w);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_n(input word_t w, input int n);
      stored_data  = w;
      shift_enable = 1'b1;
      repeat (n) tick();
      shift_enable = 1'b0;
   endtask

   // Eight shifts followed by the push cycle; the word is expected only if it will be kept.
   task automatic capture(input word_t w, input bit kept);
      shift_n(w, 8);
      if (kept) exp_q.push_back(w);
      tick();
   endtask

   task automatic drain(input int n);
      out_ready = 1'b1;
      repeat (n) tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; shift_enable = 1'b0; stored_data = '0; frame_clear = 1'b0;
      out_ready = 1'b0; clear_overflow = 1'b0;
      tick(); tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      reset = 1'b0;
      tick();

      // Single word
      shift_n(8'hB2, 8);
      chk("single_not_yet", 32'(out_valid), 0);
      exp_q.push_back(8'hB2);
      tick();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_data", 32'(out_data), 32'h B2);
      chk("single_count", 32'(fifo_count), 1);
      tick();
      chk("single_hold", 32'(out_data), 32'hB2);
      drain(1);
      chk("single_pop_count", 32'(fifo_count), 0);
      chk("single_pop_valid", 32'(out_valid), 0);

      // Back-to-back words, continuous shifting
      out_ready = 1'b1;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      shift_n(8'h11, 9);
      shift_n(8'h22, 7);
      tick();
      tick(); tick();
      out_ready = 1'b0;
      chk("b2b_count", 32'(fifo_count), 0);
      chk("b2b_ovf", 32'(overflow), 0);

      // Overflow with a stalled consumer
      for (int i = 1; i <= 5; i++) capture(word_t'(i), i <= 4);
      chk("ovf_count", 32'(fifo_count), 4);
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_head", 32'(out_data), 32'h01);
      shift_n(8'h06, 8);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 1);
      chk("ovf_count_kept", 32'(fifo_count), 4);
      drain(4);
      chk("ovf_drained", 32'(fifo_count), 0);
      chk("ovf_still_set", 32'(overflow), 1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("ovf_cleared", 32'(overflow), 0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) capture(word_t'(8'h31 + i), 1'b1);
      shift_n(8'hAA, 8);
      out_ready = 1'b1;
      exp_q.push_back(8'hAA);
      tick();
      out_ready = 1'b0;
      chk("fullpp_count", 32'(fifo_count), 4);
      chk("fullpp_ovf", 32'(overflow), 0);
      chk("fullpp_head", 32'(out_data), 32'h32);
      drain(4);
      chk("fullpp_drained", 32'(fifo_count), 0);

      // frame_clear mid-word restarts the count
      shift_n(8'h77, 3);
      frame_clear = 1'b1; shift_enable = 1'b1;
      tick();
      frame_clear = 1'b0; shift_enable = 1'b0;
      shift_n(8'hE5, 8);
      chk("fc_no_early", 32'(fifo_count), 0);
      exp_q.push_back(8'hE5);
      tick();
      chk("fc_capture", 32'(fifo_count), 1);
      drain(1);

      // frame_clear on the pending-capture cycle suppresses the push
      shift_n(8'h9C, 8);
      frame_clear = 1'b1;
      tick();
      frame_clear = 1'b0;
      tick();
      chk("fc_pending_drop", 32'(fifo_count), 0);
      chk("fc_pending_valid", 32'(out_valid), 0);
      capture(8'h4D, 1'b1);
      chk("fc_after_count", 32'(fifo_count), 1);
      drain(1);

      // Asynchronous reset mid-stream with a full FIFO and overflow set
      for (int i = 0; i < 5; i++) capture(word_t'(8'h61 + i), i < 4);
      shift_n(8'h5A, 5);
      #3 reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_data", 32'(out_data), 0);
      chk("arst_count", 32'(fifo_count), 0);
      chk("arst_ovf", 32'(overflow), 0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      shift_n(8'hC3, 8);
      chk("arst_no_stale", 32'(fifo_count), 0);
      exp_q.push_back(8'hC3);
      tick();
      chk("arst_capture", 32'(fifo_count), 1);
      chk("arst_data_c3", 32'(out_data), 32'hC3);
      drain(1);
      tick(); tick();

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
